// File: rtl/arx_pkg.sv
// rtl/arx_pkg.sv - shared types and default rotation constants for the ARX quarter-round engine
package arx_pkg;

  localparam int WORD_W = 32;

  localparam int ROT0_DEF = 16;
  localparam int ROT1_DEF = 12;
  localparam int ROT2_DEF = 8;
  localparam int ROT3_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
  } qstate_t;

endpackage

// File: rtl/arx_qround_rotl32.sv
// rtl/arx_qround_rotl32.sv - combinational 32-bit rotate-left (rotl32)
module rotl32
  import arx_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [4:0]        k,
  output logic [WORD_W-1:0] o
);

  // Rotating through a doubled word keeps k=0 an identity without any full-width shift.
  logic [2*WORD_W-1:0] dbl;

  assign dbl = {x, x} << k;
  assign o   = dbl[2*WORD_W-1:WORD_W];

endmodule

// File: rtl/arx_qround.sv
// rtl/arx_qround.sv - iterative ARX quarter-round engine, one step per cycle, shared rotator
// Optional feed-forward of the input words into the result: ARX_QROUND_FEEDFWD_EN.
module arx_qround
  import arx_pkg::*;
#(
  parameter int NQR = 1,
  parameter int R0  = ROT0_DEF,
  parameter int R1  = ROT1_DEF,
  parameter int R2  = ROT2_DEF,
  parameter int R3  = ROT3_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d
);

  if (NQR < 1 || NQR > 255) begin : g_bad_nqr
    $error("arx_qround: NQR must be in 1..255");
  end
  if (R0 < 0 || R0 > 31 || R1 < 0 || R1 > 31 || R2 < 0 || R2 > 31 || R3 < 0 || R3 > 31) begin : g_bad_rot
    $error("arx_qround: rotate amounts must be in 0..31");
  end

  localparam logic [7:0] LAST_RND = 8'(NQR - 1);

  state_t  state, next_state;
  qstate_t work, work_nxt, res, out_q;
  logic [1:0]  step;
  logic [7:0]  rnd;
  logic [4:0]  k;
  logic [31:0] sum, mix, rot;
  logic        last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (step == 2'd3) && (rnd == LAST_RND);

  always_comb begin
    case (step)
      2'd0:    k = 5'(R0);
      2'd1:    k = 5'(R1);
      2'd2:    k = 5'(R2);
      default: k = 5'(R3);
    endcase
  end

  // Even steps mix a into d, odd steps mix c into b.
  assign sum = step[0] ? (work.c + work.d) : (work.a + work.b);
  assign mix = step[0] ? (work.b ^ sum)    : (work.d ^ sum);

  rotl32 u_rotl (
    .x(mix),
    .k(k),
    .o(rot)
  );

  always_comb begin
    work_nxt = work;
    if (step[0]) begin
      work_nxt.c = sum;
      work_nxt.b = rot;
    end else begin
      work_nxt.a = sum;
      work_nxt.d = rot;
    end
  end

`ifdef ARX_QROUND_FEEDFWD_EN
  qstate_t in_copy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_copy <= '0;
    end else if (state == IDLE && in_valid) begin
      in_copy <= '{a: in_a, b: in_b, c: in_c, d: in_d};
    end
  end

  always_comb begin
    res.a = work_nxt.a + in_copy.a;
    res.b = work_nxt.b + in_copy.b;
    res.c = work_nxt.c + in_copy.c;
    res.d = work_nxt.d + in_copy.d;
  end
`else
  assign res = work_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last)      next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      out_q <= '0;
      step  <= 2'd0;
      rnd   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= '{a: in_a, b: in_b, c: in_c, d: in_d};
            step <= 2'd0;
            rnd  <= 8'd0;
          end
        end
        RUN: begin
          work <= work_nxt;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            rnd <= rnd + 8'd1;
          end
          if (last) begin
            out_q <= res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_a = out_q.a;
  assign out_b = out_q.b;
  assign out_c = out_q.c;
  assign out_d = out_q.d;

endmodule

// File: tb/tb_arx_qround.sv
// tb/tb_arx_qround.sv - directed-vector bench for arx_qround (NQR=1, NQR=4, zero-rotate instances)
module tb_arx_qround;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_a, in_b, in_c, in_d;
  logic        in_valid_v  [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        out_ready_v [3];
  logic [31:0] oa [3];
  logic [31:0] ob [3];
  logic [31:0] oc [3];
  logic [31:0] od [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arx_qround #(.NQR(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]), .out_d(od[0])
  );

  arx_qround #(.NQR(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]), .out_d(od[1])
  );

  arx_qround #(.NQR(1), .R0(0), .R1(0), .R2(0), .R3(0)) u_dutz (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_a(oa[2]), .out_b(ob[2]), .out_c(oc[2]), .out_d(od[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns in DONE with outputs checked.
  task automatic run_job(input int idx, input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ec, input logic [31:0] ed,
                         input int exp_lat);
    int cyc;
    in_a = a; in_b = b; in_c = c; in_d = d;
    check({tag, "_in_ready"}, 32'(in_ready_v[idx]), 32'd1);
    in_valid_v[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[idx] = 1'b0;
    check({tag, "_busy"}, 32'(in_ready_v[idx]), 32'd0);
    cyc = 0;
    while (!out_valid_v[idx] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_out_a"}, oa[idx], ea);
    check({tag, "_out_b"}, ob[idx], eb);
    check({tag, "_out_c"}, oc[idx], ec);
    check({tag, "_out_d"}, od[idx], ed);
  endtask

  task automatic drain(input int idx, input string tag);
    out_ready_v[idx] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[idx] = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid_v[idx]), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready_v[idx]), 32'd1);
  endtask

  logic [31:0] v1a, v1b, v1c, v1d, za, zb, zc, zd;

  initial begin
`ifdef ARX_QROUND_FEEDFWD_EN
    v1a = 32'hfb3ba405; v1b = 32'hcc1efbd2; v1c = 32'he10eb671; v1d = 32'h59a50a22;
    za  = 32'h0000000c; zb  = 32'h00000020; zc  = 32'h00000019; zd  = 32'h00000010;
`else
    v1a = 32'hea2a92f4; v1b = 32'hcb1cf8ce; v1c = 32'h4581472e; v1d = 32'h5881c4bb;
    za  = 32'h0000000b; zb  = 32'h0000001e; zc  = 32'h00000016; zd  = 32'h0000000c;
`endif
    rst = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("rst_out_a", oa[0], 32'd0);
    check("rst_out_d", od[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);

    run_job(0, "vec1", 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
            v1a, v1b, v1c, v1d, 4);

    for (int i = 0; i < 10; i++) begin
      in_valid_v[0] = i[0];
      in_a = 32'hdeadbeef; in_b = 32'hcafef00d; in_c = 32'h12345678; in_d = 32'h9abcdef0;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
      check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
      check("bp_out_a", oa[0], v1a);
      check("bp_out_d", od[0], v1d);
    end
    in_valid_v[0] = 1'b0;
    drain(0, "bp");

    run_job(0, "zero1", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4);
    drain(0, "zero1");
    run_job(1, "zero4", 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16);
    drain(1, "zero4");

    run_job(2, "rot0", 32'd1, 32'd2, 32'd3, 32'd4, za, zb, zc, zd, 4);
    drain(2, "rot0");

    run_job(0, "pre_rst", 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
            v1a, v1b, v1c, v1d, 4);
    drain(0, "pre_rst");
    in_a = 32'h11111111; in_b = 32'h01020304; in_c = 32'h9b8d6f43; in_d = 32'h01234567;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("midrst_out_a", oa[0], 32'd0);
    check("midrst_out_c", oc[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", 32'(in_ready_v[0]), 32'd1);
    run_job(0, "post_rst", 32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567,
            v1a, v1b, v1c, v1d, 4);
    drain(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
